ureg_n: RTL and testbench

Parametrised universal register: the general-purpose successor to the fixed 4-bit enable register used across the lab designs. Holds a W-bit value with synchronous reset and clock enable, and adds load, shift, rotate and up/down count modes with serial in/out, terminal-count detection and a sticky overflow flag. Used wherever a datapath needs a counter, shift register or plain register, such as crosswalk timers, pattern shifters and digit latches.

---
 rtl/ureg_n.sv | 83 ++++++++
 tb/tb_ureg_n.sv | 133 +++++++++++++
 2 files changed

// File: rtl/ureg_n.sv
// ureg_n: parametrised universal register with load, shift, rotate and
// up/down count modes, serial in/out, terminal count and sticky overflow.
module ureg_n #(
    parameter int unsigned    W         = 4,
    parameter logic [W-1:0]   RESET_VAL = '0,
    parameter bit             SAT       = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic [2:0]    mode,
    input  logic [W-1:0]  d,
    input  logic          sin,
    output logic [W-1:0]  q,
    output logic          sout,
    output logic          tc,
    output logic          ovf
);

    typedef enum logic [2:0] {
        M_HOLD  = 3'b000,
        M_LOAD  = 3'b001,
        M_SHL   = 3'b010,
        M_SHR   = 3'b011,
        M_ROL   = 3'b100,
        M_ROR   = 3'b101,
        M_UP    = 3'b110,
        M_DOWN  = 3'b111
    } mode_t;

    mode_t        op;
    logic         all_ones;
    logic         all_zero;
    logic [W-1:0] q_next;

    assign op       = mode_t'(mode);
    assign all_ones = &q;
    assign all_zero = ~|q;

    // Terminal count and serial output decode from the current q and mode
    always_comb begin
        tc   = 1'b0;
        sout = 1'b0;
        case (op)
            M_SHL, M_ROL: sout = q[W-1];
            M_SHR, M_ROR: sout = q[0];
            M_UP:         tc   = all_ones;
            M_DOWN:       tc   = all_zero;
            default:      ;
        endcase
    end

    // Next register value for the selected mode
    always_comb begin
        q_next = q;
        case (op)
            M_HOLD: q_next = q;
            M_LOAD: q_next = d;
            M_SHL:  q_next = {q[W-2:0], sin};
            M_SHR:  q_next = {sin, q[W-1:1]};
            M_ROL:  q_next = {q[W-2:0], q[W-1]};
            M_ROR:  q_next = {q[0], q[W-1:1]};
            M_UP:   q_next = (SAT && all_ones) ? q : q + 1'b1;
            M_DOWN: q_next = (SAT && all_zero) ? q : q - 1'b1;
            default: q_next = q;
        endcase
    end

    // Register and sticky overflow; tc doubles as the overflow-set condition
    always_ff @(posedge clk) begin
        if (reset) begin
            q   <= RESET_VAL;
            ovf <= 1'b0;
        end else if (en) begin
            q <= q_next;
            if (op == M_LOAD)
                ovf <= 1'b0;
            else if (tc)
                ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ureg_n.sv
// tb_ureg_n: scoreboard bench for ureg_n; a wrapping and a saturating
// instance share stimulus, expected results are queued per edge.
module tb_ureg_n;

    logic       clk;
    logic       reset;
    logic       en;
    logic [2:0] mode;
    logic [3:0] d;
    logic       sin;

    logic [3:0] q0, q1;
    logic       sout0, sout1, tc0, tc1, ovf0, ovf1;

    ureg_n #(.W(4), .RESET_VAL(4'hA), .SAT(1'b0)) dut_wrap (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .d(d), .sin(sin),
        .q(q0), .sout(sout0), .tc(tc0), .ovf(ovf0)
    );

    ureg_n #(.W(4), .RESET_VAL(4'hA), .SAT(1'b1)) dut_sat (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .d(d), .sin(sin),
        .q(q1), .sout(sout1), .tc(tc1), .ovf(ovf1)
    );

    typedef struct {
        string      name;
        logic [3:0] q0;
        logic       o0;
        logic       t0;
        logic [3:0] q1;
        logic       o1;
        logic       t1;
        logic       so;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   done   = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input string field,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s actual=%0h expected=%0h", name, field, act, exp);
        end
    endtask

    // Monitor: one result per edge, sampled 1 time unit after posedge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check(e.name, "wrap_q",    32'(q0),    32'(e.q0));
                check(e.name, "wrap_ovf",  32'(ovf0),  32'(e.o0));
                check(e.name, "wrap_tc",   32'(tc0),   32'(e.t0));
                check(e.name, "wrap_sout", 32'(sout0), 32'(e.so));
                check(e.name, "sat_q",     32'(q1),    32'(e.q1));
                check(e.name, "sat_ovf",   32'(ovf1),  32'(e.o1));
                check(e.name, "sat_tc",    32'(tc1),   32'(e.t1));
                check(e.name, "sat_sout",  32'(sout1), 32'(e.so));
            end
        end
    end

    // Drive one edge's inputs and queue the expected post-edge state
    task automatic step(input string name, input logic r, input logic e_n,
                        input logic [2:0] m, input logic [3:0] dd, input logic s,
                        input logic [3:0] eq0, input logic eo0, input logic et0,
                        input logic [3:0] eq1, input logic eo1, input logic et1,
                        input logic eso);
        exp_t x;
        @(negedge clk);
        reset = r; en = e_n; mode = m; d = dd; sin = s;
        x.name = name;
        x.q0 = eq0; x.o0 = eo0; x.t0 = et0;
        x.q1 = eq1; x.o1 = eo1; x.t1 = et1;
        x.so = eso;
        sb.push_back(x);
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; mode = 3'b000; d = 4'h0; sin = 1'b0;

        // name        rst en mode    d     sin  q0    o0 t0  q1    o1 t1  sout
        step("rst_pri",  1, 1, 3'b001, 4'h5, 0,  4'hA, 0, 0,  4'hA, 0, 0,  0);
        step("rst_rel",  0, 1, 3'b001, 4'h5, 0,  4'h5, 0, 0,  4'h5, 0, 0,  0);
        step("load3",    0, 1, 3'b001, 4'h3, 0,  4'h3, 0, 0,  4'h3, 0, 0,  0);
        for (int unsigned i = 0; i < 5; i++)
            step("en_gate",  0, 0, 3'b110, 4'h0, 0,  4'h3, 0, 0,  4'h3, 0, 0,  0);
        step("load9",    0, 1, 3'b001, 4'h9, 0,  4'h9, 0, 0,  4'h9, 0, 0,  0);
        step("shl",      0, 1, 3'b010, 4'h0, 0,  4'h2, 0, 0,  4'h2, 0, 0,  0);
        step("shr",      0, 1, 3'b011, 4'h0, 1,  4'h9, 0, 0,  4'h9, 0, 0,  1);
        step("rol",      0, 1, 3'b100, 4'h0, 0,  4'h3, 0, 0,  4'h3, 0, 0,  0);
        step("ror",      0, 1, 3'b101, 4'h0, 0,  4'h9, 0, 0,  4'h9, 0, 0,  1);
        step("loadE",    0, 1, 3'b001, 4'hE, 0,  4'hE, 0, 0,  4'hE, 0, 0,  0);
        step("up_F",     0, 1, 3'b110, 4'h0, 0,  4'hF, 0, 1,  4'hF, 0, 1,  0);
        step("up_wrap",  0, 1, 3'b110, 4'h0, 0,  4'h0, 1, 0,  4'hF, 1, 1,  0);
        step("up_1",     0, 1, 3'b110, 4'h0, 0,  4'h1, 1, 0,  4'hF, 1, 1,  0);
        step("hold_ovf", 0, 1, 3'b000, 4'h0, 0,  4'h1, 1, 0,  4'hF, 1, 0,  0);
        step("load1",    0, 1, 3'b001, 4'h1, 0,  4'h1, 0, 0,  4'h1, 0, 0,  0);
        step("dn_0",     0, 1, 3'b111, 4'h0, 0,  4'h0, 0, 1,  4'h0, 0, 1,  0);
        step("dn_lim",   0, 1, 3'b111, 4'h0, 0,  4'hF, 1, 0,  4'h0, 1, 1,  0);
        step("dn_more",  0, 1, 3'b111, 4'h0, 0,  4'hE, 1, 0,  4'h0, 1, 1,  0);
        step("en0_load", 0, 0, 3'b001, 4'h7, 0,  4'hE, 1, 0,  4'h0, 1, 0,  0);
        step("load7",    0, 1, 3'b001, 4'h7, 0,  4'h7, 0, 0,  4'h7, 0, 0,  0);
        step("load0",    0, 1, 3'b001, 4'h0, 0,  4'h0, 0, 0,  4'h0, 0, 0,  0);
        for (int unsigned i = 1; i <= 6; i++)
            step("cnt_up",   0, 1, 3'b110, 4'h0, 0,  4'(i), 0, 0,  4'(i), 0, 0,  0);
        step("mid_rst",  1, 1, 3'b110, 4'h0, 0,  4'hA, 0, 0,  4'hA, 0, 0,  0);
        step("resume1",  0, 1, 3'b110, 4'h0, 0,  4'hB, 0, 0,  4'hB, 0, 0,  0);
        step("resume2",  0, 1, 3'b110, 4'h0, 0,  4'hC, 0, 0,  4'hC, 0, 0,  0);

        for (int unsigned i = 0; i < 10 && sb.size() > 0; i++)
            @(negedge clk);
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
